// File: rtl/led_mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : led_mode_sequencer                                              |
// | Routes one of up to four LED mode drivers to the LED bank, with a dark     |
// | blanking gap and a driver restart pulse between modes.                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module led_mode_sequencer #(
  parameter int MODE_COUNT   = 4,
  parameter int DWELL_CYCLES = 60000000,
  parameter int BLANK_CYCLES = 1200000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mode0_led,
  input  logic [7:0] mode1_led,
  input  logic [7:0] mode2_led,
  input  logic [7:0] mode3_led,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  output logic [7:0] led_out,
  output logic [1:0] mode_sel,
  output logic       drv_restart,
  output logic       blanking
);

  localparam logic [1:0]       c_LAST_SEL   = 2'(MODE_COUNT - 1);
  localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_dwell, w_dwell_nxt;
  logic [CNT_W-1:0] r_blank, w_blank_nxt;
  logic [7:0]       w_led_sel, w_led_nxt;
  logic [1:0]       w_sel_nxt, w_sel_fwd, w_sel_back;
  logic             w_btn_evt, w_auto_evt, w_back;
  logic             w_restart_nxt, w_blanking_nxt;

  // Indices at or above MODE_COUNT never reach the LED bank.
  always_comb begin
    w_led_sel = 8'h00;
    case (mode_sel)
      2'd0:    w_led_sel = mode0_led;
      2'd1:    if (MODE_COUNT > 1) w_led_sel = mode1_led;
      2'd2:    if (MODE_COUNT > 2) w_led_sel = mode2_led;
      default: if (MODE_COUNT > 3) w_led_sel = mode3_led;
    endcase
  end

  assign w_sel_fwd  = (mode_sel == c_LAST_SEL) ? 2'd0 : mode_sel + 2'd1;
  assign w_sel_back = (mode_sel == 2'd0) ? c_LAST_SEL : mode_sel - 2'd1;

  // Opposing presses cancel; a lone prev overrides the auto direction.
  assign w_btn_evt  = btn_next ^ btn_prev;
  assign w_auto_evt = auto_en && (r_dwell == c_DWELL_LAST);
  assign w_back     = btn_prev & ~btn_next;

  always_comb begin
    w_state_nxt    = r_state;
    w_dwell_nxt    = r_dwell;
    w_blank_nxt    = '0;
    w_sel_nxt      = mode_sel;
    w_led_nxt      = 8'h00;
    w_restart_nxt  = 1'b0;
    w_blanking_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_btn_evt || w_auto_evt) begin
          w_state_nxt    = ST_BLANK;
          w_dwell_nxt    = '0;
          w_sel_nxt      = w_back ? w_sel_back : w_sel_fwd;
          w_blanking_nxt = 1'b1;
        end else begin
          w_led_nxt = w_led_sel;
          if (auto_en) w_dwell_nxt = r_dwell + c_CNT_ONE;
        end
      end
      ST_BLANK: begin
        w_dwell_nxt = '0;
        if (r_blank == c_BLANK_LAST) begin
          w_state_nxt   = ST_RUN;
          w_restart_nxt = 1'b1;
        end else begin
          w_blank_nxt    = r_blank + c_CNT_ONE;
          w_blanking_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_dwell     <= '0;
      r_blank     <= '0;
      mode_sel    <= 2'd0;
      led_out     <= 8'h00;
      drv_restart <= 1'b0;
      blanking    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dwell     <= w_dwell_nxt;
      r_blank     <= w_blank_nxt;
      mode_sel    <= w_sel_nxt;
      led_out     <= w_led_nxt;
      drv_restart <= w_restart_nxt;
      blanking    <= w_blanking_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_led_mode_sequencer                                           |
// | Self-checking bench for led_mode_sequencer (3 modes, dwell 20, blank 4).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_led_mode_sequencer;

  typedef struct {
    logic       rst;
    logic       nx;
    logic       pv;
    logic       au;
    logic [7:0] led;
    logic [1:0] sel;
    logic       rs;
    logic       bl;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mode0_led = 8'h01;
  logic [7:0] mode1_led = 8'h02;
  logic [7:0] mode2_led = 8'h04;
  logic [7:0] mode3_led = 8'h08;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       auto_en = 1'b0;
  logic [7:0] led_out;
  logic [1:0] mode_sel;
  logic       drv_restart;
  logic       blanking;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  led_mode_sequencer #(
    .MODE_COUNT  (3),
    .DWELL_CYCLES(20),
    .BLANK_CYCLES(4),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode0_led  (mode0_led),
    .mode1_led  (mode1_led),
    .mode2_led  (mode2_led),
    .mode3_led  (mode3_led),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .auto_en    (auto_en),
    .led_out    (led_out),
    .mode_sel   (mode_sel),
    .drv_restart(drv_restart),
    .blanking   (blanking)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic n, input logic p, input logic a,
                              input logic [7:0] led, input logic [1:0] sel,
                              input logic rs, input logic bl, input int rep = 1);
    vec_t v;
    v.rst = r; v.nx = n; v.pv = p; v.au = a;
    v.led = led; v.sel = sel; v.rs = rs; v.bl = bl;
    for (int k = 0; k < rep; k++) tbl.push_back(v);
  endfunction

  // Event cycle, four dark cycles (ign presses injected there), restart, then the new mode.
  function automatic void add_adv(input logic n, input logic p, input logic ign,
                                  input logic [1:0] sel, input logic [7:0] led);
    add(0, n, p, 0, 8'h00, sel, 0, 1);
    add(0, ign, 0, ign, 8'h00, sel, 0, 1, 3);
    add(0, ign, 0, ign, 8'h00, sel, 1, 0);
    add(0, 0, 0, 0, led, sel, 0, 0, 3);
  endfunction

  task automatic count_until(input bit want_restart, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_restart ? drv_restart : blanking) && n < 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   n;
    int   restarts;

    add(1, 0, 0, 0, 8'h00, 2'd0, 0, 0, 2);
    add(0, 0, 0, 0, 8'h01, 2'd0, 0, 0, 6);
    add_adv(1, 0, 0, 2'd1, 8'h02);
    add_adv(1, 0, 0, 2'd2, 8'h04);
    add_adv(1, 0, 0, 2'd0, 8'h01);
    add_adv(0, 1, 0, 2'd2, 8'h04);
    add(0, 1, 1, 0, 8'h04, 2'd2, 0, 0);
    add(0, 0, 0, 0, 8'h04, 2'd2, 0, 0, 4);
    add_adv(1, 0, 1, 2'd0, 8'h01);
    add_adv(0, 1, 0, 2'd2, 8'h04);
    add(1, 0, 0, 0, 8'h00, 2'd0, 0, 0);
    add(0, 0, 0, 0, 8'h01, 2'd0, 0, 0, 4);

    for (int i = 0; i <= tbl.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("vec%0d led_out", i - 1), int'(led_out), int'(e.led));
        chk($sformatf("vec%0d mode_sel", i - 1), int'(mode_sel), int'(e.sel));
        chk($sformatf("vec%0d drv_restart", i - 1), int'(drv_restart), int'(e.rs));
        chk($sformatf("vec%0d blanking", i - 1), int'(blanking), int'(e.bl));
      end
      if (i < tbl.size()) begin
        rst = tbl[i].rst; btn_next = tbl[i].nx; btn_prev = tbl[i].pv; auto_en = tbl[i].au;
        sb.push_back(tbl[i]);
      end
    end
    rst = 0; btn_next = 0; btn_prev = 0; auto_en = 0;

    // Auto-advance from mode 0, auto_en held high through the blank gap.
    auto_en = 1;
    count_until(0, n);
    chk("auto dwell cycles", n, 20);
    chk("auto mode_sel", int'(mode_sel), 1);
    count_until(1, n);
    chk("auto blank cycles", n, 4);
    chk("auto restart led", int'(led_out), 8'h00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("auto new led", int'(led_out), 8'h02);
    end while (!blanking && n < 100);
    chk("auto second dwell", n, 20);
    chk("auto second sel", int'(mode_sel), 2);
    count_until(1, n);

    // Pause the dwell timer for 10 cycles mid-dwell.
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 5) auto_en = 0;
      if (n == 15) auto_en = 1;
    end while (!blanking && n < 100);
    auto_en = 0;
    chk("paused dwell cycles", n, 30);
    chk("paused wrap sel", int'(mode_sel), 0);
    count_until(1, n);
    @(negedge clk);
    chk("paused new led", int'(led_out), 8'h01);

    // Reset during the second blank cycle.
    btn_next = 1;
    @(negedge clk);
    btn_next = 0;
    chk("midblank entered", int'(blanking), 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midblank rst blanking", int'(blanking), 0);
    chk("midblank rst sel", int'(mode_sel), 0);
    chk("midblank rst led", int'(led_out), 8'h00);
    restarts = int'(drv_restart);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      restarts += int'(drv_restart);
    end
    chk("midblank no restart", restarts, 0);
    chk("midblank led after", int'(led_out), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
